fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 32, meaning instruction word-address width.
REQ-003 SHALL have parameter DW, default 32, meaning instruction width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its negedge, matching the pipeline latches.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port imem_req  out  1  program-memory read strobe.
REQ-007 SHALL have port imem_addr  out  AW  word address of the read.
REQ-008 SHALL have port imem_rdata  in  DW  read data, valid exactly one clk after imem_req.
REQ-009 SHALL have port redirect  in  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirect_pc  in  AW  new fetch address.
REQ-011 SHALL have port out_valid  out  1  head entry available to the IR/PC_1 latch.
REQ-012 SHALL have port out_ready  in  1  decode latch accepts head.
REQ-013 SHALL have port out_ir  out  DW  head instruction.
REQ-014 SHALL have port out_pc_1  out  AW  head fetch address + 1.
REQ-015 SHALL have port count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and FLUSH; IDLE -> RUN on the first clk with rst high, RUN -> FLUSH on redirect, FLUSH -> RUN after one clk.
REQ-017 SHALL assert imem_req in RUN only when count + inflight < DEPTH and redirect is low; never in IDLE or FLUSH.
REQ-018 SHALL drive imem_addr = fetch_pc and, on each issued req, advance fetch_pc by 1 modulo 2^AW (0xFFFFFFFF wraps to 0).
REQ-019 SHALL set inflight on an issued req, capture imem_rdata with addr+1 into the tail one clk later, then clear inflight.
REQ-020 SHALL present the head on out_ir/out_pc_1 with out_valid = (count != 0); pop on out_valid && out_ready.
REQ-021 SHALL support simultaneous push and pop in one clk, count unchanged; pointers wrap modulo DEPTH.
REQ-022 SHALL make overflow impossible via REQ-017; a pop on empty SHALL be ignored.
REQ-023 SHALL, on redirect, empty the queue, load fetch_pc with redirect_pc, drop the pending response (if inflight), and ignore any same-cycle pop.
REQ-024 SHALL issue the first post-redirect req from redirect_pc on the clk after FLUSH.
REQ-025 SHALL hold out_ir/out_pc_1 stable while out_valid && !out_ready.
REQ-026 SHALL, without bypass, give req-to-out_valid latency of 2 clk.

Reset
REQ-027 SHALL, when rst is low at a clk edge, force state IDLE, fetch_pc 0, inflight 0, count 0, out_valid 0, imem_req 0, out_ir 0, out_pc_1 0.
REQ-028 SHALL give reset priority over redirect and any in-flight response; a response arriving after reset SHALL be dropped.

Configuration
REQ-029 SHALL support macro FETCH_BYPASS_EN: when defined and the queue is empty, an arriving response drives out_ir/out_pc_1/out_valid in the same clk (latency 1); it is enqueued only if out_ready is low.
REQ-030 SHALL, without FETCH_BYPASS_EN, always enqueue responses (latency 2, REQ-026).

Structure
REQ-031 SHALL take DEPTH default, state encoding (IDLE/RUN/FLUSH) and width constants from shared package fetch_pkg.
REQ-032 SHALL place storage and pointers in one sub-module fetch_fifo (push/pop/clear, count).

Verification
REQ-033 SHALL cover reset release with out_ready=1 -> imem_addr 0,1,2... each clk; out_ir in order, out_pc_1 = 1,2,3; first out_valid 2 clk after first req.
REQ-034 SHALL cover out_ready=0 for 10 clk -> count reaches 4, imem_req low, no data loss; ready=1 -> 4 words drain in order.
REQ-035 SHALL cover redirect to 0x40 with inflight set and 3 entries queued -> count 0 next clk, dropped word never appears, next imem_addr 0x40, out_pc_1 0x41.
REQ-036 SHALL cover fetch_pc 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0; out_pc_1 0xFFFFFFFF, 0x0, 0x1.
REQ-037 SHALL cover rst low mid-stream with a response pending -> all outputs 0 next clk, pending word discarded, restart at address 0.
REQ-038 SHALL cover FETCH_BYPASS_EN defined, empty queue -> out_valid in the clk after req, count stays 0 with out_ready=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and FSM state encoding for the instruction fetch queue.
package fetch_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_AW    = 32;
  localparam int FQ_DW    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fq_state_e;

  // Width of an occupancy counter able to hold every value from 0 to depth.
  function automatic int fq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular store of {instruction, fetch address + 1} pairs.
// State changes on the falling clock edge, like the rest of the fetch pipeline.
// Clear has priority over push and pop. A pop on empty is ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = FQ_AW,
  parameter int DW    = FQ_DW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DW-1:0]                push_ir_i,
  input  logic [AW-1:0]                push_pc1_i,
  output logic [DW-1:0]                head_ir_o,
  output logic [AW-1:0]                head_pc1_o,
  output logic [fq_cnt_w(DEPTH)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = fq_cnt_w(DEPTH);

  logic [DW-1:0] ir_mem_q  [DEPTH];
  logic [AW-1:0] pc1_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_s, full_s, push_ok_s, pop_ok_s;

  assign empty_s   = (count_q == {CW{1'b0}});
  assign full_s    = (count_q == CW'(DEPTH));
  assign pop_ok_s  = pop_i && !empty_s;
  assign push_ok_s = push_i && (!full_s || pop_ok_s);

  // Next pointer and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (pop_ok_s)  rd_ptr_d = rd_ptr_q + PW'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(negedge clk) begin
    if (!rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only visible while the entry is counted.
  always_ff @(negedge clk) begin
    if (push_ok_s && !clear_i) begin
      ir_mem_q[wr_ptr_q]  <= push_ir_i;
      pc1_mem_q[wr_ptr_q] <= push_pc1_i;
    end
  end

  assign head_ir_o  = empty_s ? {DW{1'b0}} : ir_mem_q[rd_ptr_q];
  assign head_pc1_o = empty_s ? {AW{1'b0}} : pc1_mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: prefetches program-memory words into a small queue ahead of decode.
// Optional macro FETCH_BYPASS_EN forwards a response arriving at an empty queue
// straight to the outputs (latency 1); without it every response is enqueued first.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = FQ_AW,
  parameter int DW    = FQ_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [AW-1:0]              imem_addr,
  input  logic [DW-1:0]              imem_rdata,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_ir,
  output logic [AW-1:0]              out_pc_1,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int CW = fq_cnt_w(DEPTH);

  fq_state_e     state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;

  logic [CW:0]   occ_s;
  logic          req_s, resp_s, push_s, pop_s, fifo_empty_s;
  logic [DW-1:0] fifo_ir_s;
  logic [AW-1:0] fifo_pc1_s;

  // Queued entries plus the outstanding read must stay below DEPTH so a push never overflows.
  assign occ_s        = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign req_s        = (state_q == RUN) && !redirect && (occ_s < (CW+1)'(DEPTH));
  assign fifo_empty_s = (count == {CW{1'b0}});
  // fetch_pc already points one past the outstanding read, so it is that word's pc_1.
  assign resp_s       = inflight_q && !redirect;
  assign pop_s        = out_ready && !redirect && !fifo_empty_s;

  assign imem_req  = req_s;
  assign imem_addr = fetch_pc_q;

`ifdef FETCH_BYPASS_EN
  logic bypass_s;
  assign bypass_s  = fifo_empty_s && resp_s;
  assign push_s    = resp_s && !(bypass_s && out_ready);
  assign out_valid = !fifo_empty_s || bypass_s;
  assign out_ir    = bypass_s ? imem_rdata : fifo_ir_s;
  assign out_pc_1  = bypass_s ? fetch_pc_q : fifo_pc1_s;
`else
  assign push_s    = resp_s;
  assign out_valid = !fifo_empty_s;
  assign out_ir    = fifo_ir_s;
  assign out_pc_1  = fifo_pc1_s;
`endif

  // Next FSM state, fetch address and outstanding-read flag; redirect overrides normal sequencing.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    if (redirect) begin
      state_d    = FLUSH;
      fetch_pc_d = redirect_pc;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = RUN;
        FLUSH:   state_d = RUN;
        default: state_d = IDLE;
      endcase
      if (req_s) begin
        fetch_pc_d = fetch_pc_q + AW'(1);
        inflight_d = 1'b1;
      end else begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
      end
    end
  end

  // FSM and fetch-address registers; reset beats redirect and drops any pending response.
  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= {AW{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (redirect),
    .push_i     (push_s),
    .pop_i      (pop_s),
    .push_ir_i  (imem_rdata),
    .push_pc1_i (fetch_pc_q),
    .head_ir_o  (fifo_ir_s),
    .head_pc1_o (fifo_pc1_s),
    .count_o    (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven directed bench for fetch_queue (default parameters).
// Each row drives one clock period and lists the outputs expected during it.
// The bench also plays program memory: a word requested in one period is returned
// in the next, with contents addr ^ 0xA5A50000.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_pc_1;
  logic [2:0]  count;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ir      (out_ir),
    .out_pc_1    (out_pc_1),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc1;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic        prev_req;
  logic [31:0] prev_addr;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic add(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc,
                     input logic rq, input logic [31:0] ad, input logic v,
                     input logic [31:0] p1, input logic [2:0] c);
    vec_t e;
    e.rst = r; e.ready = rdy; e.redir = rd; e.rpc = rpc;
    e.req = rq; e.addr = ad; e.valid = v; e.pc1 = p1; e.cnt = c;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_ir;
`ifdef FETCH_BYPASS_EN
    // Empty queue: response goes straight out, count stays 0 while ready is high.
    add(0,1,0,32'h0, 0,32'h0, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 0,32'h0, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'h0, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'h1, 1,32'h1,3'd0);
    add(1,1,0,32'h0, 1,32'h2, 1,32'h2,3'd0);
    add(1,0,0,32'h0, 1,32'h3, 1,32'h3,3'd0);
    add(1,0,0,32'h0, 1,32'h4, 1,32'h3,3'd1);
`else
    // reset, then streaming with ready high
    add(0,1,0,32'h0, 0,32'h0, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 0,32'h0, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'h0, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'h1, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'h2, 1,32'h1,3'd1);
    add(1,1,0,32'h0, 1,32'h3, 1,32'h2,3'd1);
    // ready low for 10 periods: fills to 4, requests stop
    add(1,0,0,32'h0, 1,32'h4, 1,32'h3,3'd1);
    add(1,0,0,32'h0, 1,32'h5, 1,32'h3,3'd2);
    add(1,0,0,32'h0, 0,32'h6, 1,32'h3,3'd3);
    for (int i = 0; i < 7; i++) add(1,0,0,32'h0, 0,32'h6, 1,32'h3,3'd4);
    // drain in order, fetching resumes
    add(1,1,0,32'h0, 0,32'h6, 1,32'h3,3'd4);
    add(1,1,0,32'h0, 1,32'h6, 1,32'h4,3'd3);
    add(1,1,0,32'h0, 1,32'h7, 1,32'h5,3'd2);
    add(1,1,0,32'h0, 1,32'h8, 1,32'h6,3'd2);
    add(1,0,0,32'h0, 1,32'h9, 1,32'h7,3'd2);
    // redirect to 0x40 with 3 queued and one read outstanding; same-cycle pop ignored
    add(1,1,1,32'h40, 0,32'hA, 1,32'h7,3'd3);
    add(1,1,0,32'h0, 0,32'h40, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'h40, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'h41, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'h42, 1,32'h41,3'd1);
    // address wrap from 0xFFFFFFFE
    add(1,1,1,32'hFFFF_FFFE, 0,32'h43, 1,32'h42,3'd1);
    add(1,1,0,32'h0, 0,32'hFFFF_FFFE, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'hFFFF_FFFE, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'hFFFF_FFFF, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'h0, 1,32'hFFFF_FFFF,3'd1);
    add(1,1,0,32'h0, 1,32'h1, 1,32'h0,3'd1);
    add(1,1,0,32'h0, 1,32'h2, 1,32'h1,3'd1);
    // reset mid-stream with a response pending, then restart from 0
    add(0,1,0,32'h0, 1,32'h3, 1,32'h2,3'd1);
    add(1,1,0,32'h0, 0,32'h0, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'h0, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'h1, 0,32'h0,3'd0);
    add(1,1,0,32'h0, 1,32'h2, 1,32'h1,3'd1);
`endif

    // Hand sequence: hold reset across two falling edges before the table starts.
    rst = 1'b0; out_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    imem_rdata = 32'hDEAD_BEEF;
    prev_req = 1'b0; prev_addr = 32'h0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      imem_rdata  = prev_req ? memw(prev_addr) : 32'hDEAD_BEEF;
      rst         = tbl[i].rst;
      out_ready   = tbl[i].ready;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      #1;
      exp_ir = tbl[i].valid ? memw(tbl[i].pc1 - 32'd1) : 32'h0;
      chk("imem_req",  i, 32'(imem_req),  32'(tbl[i].req));
      chk("imem_addr", i, imem_addr,      tbl[i].addr);
      chk("out_valid", i, 32'(out_valid), 32'(tbl[i].valid));
      chk("out_pc_1",  i, out_pc_1,       tbl[i].pc1);
      chk("out_ir",    i, out_ir,         exp_ir);
      chk("count",     i, 32'(count),     32'(tbl[i].cnt));
      prev_req  = imem_req;
      prev_addr = imem_addr;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
